// File: rtl/output_deskew_stream.sv
// output_deskew_stream
// Realigns the diagonally skewed column results of an N-lane systolic grid
// into whole rows, tags the last row of each tile and queues the rows in a
// small FIFO drained over a ready/valid stream.
// Optional build macro OUTBUF_OVF_DETECT_EN: when defined, a sticky ovf flag
// records any row dropped because the FIFO was full; when undefined, ovf is
// tied low and no detection logic exists.
module output_deskew_stream #(
    parameter int N            = 4,
    parameter int RESULT_WIDTH = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int ROWS         = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [N*RESULT_WIDTH-1:0]     col_input,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N*RESULT_WIDTH-1:0]     out_data,
    output logic                          out_last,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          ovf
);

    localparam int RW      = RESULT_WIDTH;
    localparam int ROW_W   = N * RW;
    localparam int IDX_W   = $clog2(FIFO_DEPTH);
    localparam int PTR_W   = IDX_W + 1;
    localparam int CNT_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int ENTRY_W = ROW_W + 1;

    // ------------------------------------------------------------------
    // Deskew delay lines: lane i is delayed N-1-i cycles so every lane of
    // a row lines up with lane N-1, which feeds the FIFO directly.
    // ------------------------------------------------------------------
    logic [ROW_W-1:0] aligned_row;

    assign aligned_row[(N-1)*RW +: RW] = col_input[(N-1)*RW +: RW];

    for (genvar i = 0; i < N - 1; i++) begin : g_lane
        localparam int DEPTH = N - 1 - i;

        logic [RW-1:0] dly_q [DEPTH];
        logic [RW-1:0] dly_d [DEPTH];

        // Shift the lane one stage per cycle; the grid never stalls.
        // NOTE: combinational logic uses blocking '=', state uses '<=' so
        // every flop samples the pre-edge value of its neighbour.
        always_comb begin
            dly_d[0] = col_input[i*RW +: RW];
            for (int k = 1; k < DEPTH; k++) begin
                dly_d[k] = dly_q[k-1];
            end
        end

        // Delay-line registers; cleared by reset only, flush leaves data alone.
        always_ff @(posedge clk) begin
            if (reset) begin
                dly_q <= '{default: '0};
            end else begin
                dly_q <= dly_d;
            end
        end

        assign aligned_row[i*RW +: RW] = dly_q[DEPTH-1];
    end

    // ------------------------------------------------------------------
    // Row-valid pipeline: in_valid travels alongside lane 0's data and
    // emerges as push when the whole row is aligned.
    // ------------------------------------------------------------------
    logic push;

    if (N > 1) begin : g_vld
        logic [N-2:0] vld_q;
        logic [N-2:0] vld_d;

        // Advance the valid shift register; flush empties it.
        always_comb begin
            vld_d    = vld_q << 1;
            vld_d[0] = in_valid;
            if (flush) begin
                vld_d = '0;
            end
        end

        // Valid shift register state.
        always_ff @(posedge clk) begin
            if (reset) begin
                vld_q <= '0;
            end else begin
                vld_q <= vld_d;
            end
        end

        assign push = vld_q[N-2];
    end else begin : g_vld_bypass
        assign push = in_valid;
    end

    // ------------------------------------------------------------------
    // Aligned-row FIFO with wrap-bit pointers and tile row counter.
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   row_cnt_q, row_cnt_d;
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];
    logic [ENTRY_W-1:0] head;
    logic               full;
    logic               pop;
    logic               push_ok;
    logic               row_tag;

    assign level     = wr_ptr_q - rd_ptr_q;
    assign full      = (level == PTR_W'(FIFO_DEPTH));
    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready;
    // A push into a full FIFO only fits if the head leaves in the same cycle.
    assign push_ok   = push & (~full | pop);
    assign row_tag   = (row_cnt_q == CNT_W'(ROWS - 1));
    assign head      = mem_q[rd_ptr_q[IDX_W-1:0]];
    // Outputs are forced low while empty so stale storage never leaks out.
    assign out_data  = out_valid ? head[ROW_W-1:0] : '0;
    assign out_last  = out_valid & head[ROW_W];

    // Next-state for pointers, row counter and storage; flush wins over
    // push and pop.
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        row_cnt_d = row_cnt_q;
        mem_d     = mem_q;
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            row_cnt_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q[IDX_W-1:0]] = {row_tag, aligned_row};
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                row_cnt_d = row_tag ? '0 : row_cnt_q + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Control state: pointers and row counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            row_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    // FIFO storage.
    // NOTE: storage has no reset; an entry is only visible after it has
    // been written, and the empty case gates the outputs to zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // ------------------------------------------------------------------
    // Overflow detection (optional).
    // ------------------------------------------------------------------
`ifdef OUTBUF_OVF_DETECT_EN
    logic ovf_q, ovf_d;
    logic push_ovf;

    // A push that finds the FIFO full with no pop is dropped; remember it.
    assign push_ovf = push & full & ~pop & ~flush;

    // Sticky flag: only reset clears it.
    always_comb begin
        ovf_d = ovf_q | push_ovf;
    end

    // Overflow flag state.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_output_deskew_stream.sv
// Directed self-checking bench for output_deskew_stream.
// Main instance: N=4, RESULT_WIDTH=32, FIFO_DEPTH=4, ROWS=4.
// Second instance: N=1, RESULT_WIDTH=8, FIFO_DEPTH=2, ROWS=2.
module tb_output_deskew_stream;

`ifdef OUTBUF_OVF_DETECT_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic [127:0] col_input;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;
    logic [2:0]   level;
    logic         ovf;

    logic         flush1;
    logic         in_valid1;
    logic [7:0]   col_input1;
    logic         out_valid1;
    logic         out_ready1;
    logic [7:0]   out_data1;
    logic         out_last1;
    logic [1:0]   level1;
    logic         ovf1;

    int n_checks = 0;
    int n_errors = 0;

    logic hv [4];
    int   hr [4];

    output_deskew_stream #(
        .N(4), .RESULT_WIDTH(32), .FIFO_DEPTH(4), .ROWS(4)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .col_input(col_input), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .level(level), .ovf(ovf)
    );

    output_deskew_stream #(
        .N(1), .RESULT_WIDTH(8), .FIFO_DEPTH(2), .ROWS(2)
    ) dut1 (
        .clk(clk), .reset(reset), .flush(flush1), .in_valid(in_valid1),
        .col_input(col_input1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1), .out_last(out_last1), .level(level1), .ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] row_val(input int r, input int i);
        return 32'((r << 8) | (32'hA0 + i));
    endfunction

    function automatic logic [127:0] row_word(input int r);
        logic [127:0] w;
        for (int i = 0; i < 4; i++) w[i*32 +: 32] = row_val(r, i);
        return w;
    endfunction

    // Drive one cycle of skewed stimulus: lane i presents the row launched
    // i cycles ago, other lanes carry junk. Returns #1 after the next edge.
    task automatic tick(input logic v, input int r);
        for (int i = 3; i > 0; i--) begin
            hv[i] = hv[i-1];
            hr[i] = hr[i-1];
        end
        hv[0] = v;
        hr[0] = r;
        in_valid = v;
        for (int i = 0; i < 4; i++)
            col_input[i*32 +: 32] = hv[i] ? row_val(hr[i], i) : (32'hDEAD_0000 | 32'(i));
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick(1'b0, 0);
        flush = 1'b0;
    endtask

    initial begin
        logic seen;
        for (int i = 0; i < 4; i++) begin
            hv[i] = 1'b0;
            hr[i] = 0;
        end
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; col_input = '0; out_ready = 1'b0;
        flush1 = 1'b0; in_valid1 = 1'b0; col_input1 = '0; out_ready1 = 1'b0;

        // Reset state
        tick(1'b0, 0);
        tick(1'b0, 0);
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_data",  out_data,         128'(0));
        check("rst_last",  128'(out_last),  128'(0));
        check("rst_level", 128'(level),     128'(0));
        check("rst_ovf",   128'(ovf),       128'(0));
        check("rst_valid1", 128'(out_valid1), 128'(0));
        reset = 1'b0;

        // Single row, latency and hold under backpressure
        out_ready = 1'b0;
        tick(1'b1, 0);
        tick(1'b0, 0);
        tick(1'b0, 0);
        check("lat_early_valid", 128'(out_valid), 128'(0));
        tick(1'b0, 0);
        check("t1_valid", 128'(out_valid), 128'(1));
        check("t1_data",  out_data, 128'h000000A3_000000A2_000000A1_000000A0);
        check("t1_level", 128'(level), 128'(1));
        check("t1_last",  128'(out_last), 128'(0));
        tick(1'b0, 0);
        tick(1'b0, 0);
        check("t1_hold_valid", 128'(out_valid), 128'(1));
        check("t1_hold_data",  out_data, 128'h000000A3_000000A2_000000A1_000000A0);
        out_ready = 1'b1;
        tick(1'b0, 0);
        check("t1_drain_level", 128'(level), 128'(0));
        check("t1_drain_data",  out_data, 128'(0));
        do_flush();

        // Back-to-back rows with out_ready high, tile-end tagging
        out_ready = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            if (k <= 5) tick(1'b1, k);
            else        tick(1'b0, 0);
            if (k >= 4 && k <= 8) begin
                check($sformatf("t2_valid_%0d", k), 128'(out_valid), 128'(1));
                check($sformatf("t2_data_%0d", k),  out_data, row_word(k - 3));
                check($sformatf("t2_last_%0d", k),  128'(out_last), 128'((k - 3) == 4));
                check($sformatf("t2_level_%0d", k), 128'(level), 128'(1));
            end else begin
                check($sformatf("t2_valid_%0d", k), 128'(out_valid), 128'(0));
            end
        end

        // Overflow: five rows into a four-entry FIFO with no pops
        do_flush();
        out_ready = 1'b0;
        for (int r = 1; r <= 5; r++) tick(1'b1, r);
        tick(1'b0, 0);
        tick(1'b0, 0);
        check("t3_level_full", 128'(level), 128'(4));
        check("t3_ovf_before", 128'(ovf), 128'(0));
        tick(1'b0, 0);
        check("t3_level_sat", 128'(level), 128'(4));
        check("t3_ovf", 128'(ovf), 128'(OVF_EXP));
        out_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            check($sformatf("t3_drain_data_%0d", j), out_data, row_word(j));
            check($sformatf("t3_drain_last_%0d", j), 128'(out_last), 128'(j == 4));
            tick(1'b0, 0);
        end
        check("t3_empty_valid", 128'(out_valid), 128'(0));
        check("t3_empty_level", 128'(level), 128'(0));
        do_flush();
        check("t3_ovf_sticky", 128'(ovf), 128'(OVF_EXP));

        // Full FIFO with push and pop in the same cycle
        reset = 1'b1;
        tick(1'b0, 0);
        reset = 1'b0;
        check("t4_ovf_reset", 128'(ovf), 128'(0));
        out_ready = 1'b0;
        for (int r = 1; r <= 5; r++) tick(1'b1, r);
        tick(1'b0, 0);
        tick(1'b0, 0);
        check("t4_level_full", 128'(level), 128'(4));
        out_ready = 1'b1;
        tick(1'b0, 0);
        out_ready = 1'b0;
        check("t4_level_same", 128'(level), 128'(4));
        check("t4_head", out_data, row_word(2));
        check("t4_no_ovf", 128'(ovf), 128'(0));
        out_ready = 1'b1;
        for (int j = 2; j <= 5; j++) begin
            check($sformatf("t4_drain_data_%0d", j), out_data, row_word(j));
            check($sformatf("t4_drain_last_%0d", j), 128'(out_last), 128'(j == 4));
            tick(1'b0, 0);
        end
        check("t4_empty_level", 128'(level), 128'(0));

        // Flush with two queued rows and one in flight
        do_flush();
        out_ready = 1'b0;
        tick(1'b1, 1);
        tick(1'b1, 2);
        tick(1'b0, 0);
        tick(1'b1, 3);
        tick(1'b0, 0);
        check("t5_level_pre", 128'(level), 128'(2));
        flush = 1'b1;
        tick(1'b0, 0);
        flush = 1'b0;
        check("t5_level_post", 128'(level), 128'(0));
        check("t5_valid_post", 128'(out_valid), 128'(0));
        for (int k = 0; k < 4; k++) tick(1'b0, 0);
        check("t5_inflight_dropped", 128'(level), 128'(0));
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if (k <= 4) tick(1'b1, 10 + k);
            else        tick(1'b0, 0);
            if (k >= 4 && k <= 7) begin
                check($sformatf("t5_new_data_%0d", k), out_data, row_word(k + 7));
                check($sformatf("t5_new_last_%0d", k), 128'(out_last), 128'(k == 7));
            end
        end

        // Reset in the middle of a stream
        out_ready = 1'b1;
        tick(1'b1, 1);
        tick(1'b1, 2);
        reset = 1'b1;
        tick(1'b0, 0);
        reset = 1'b0;
        check("t6_valid", 128'(out_valid), 128'(0));
        check("t6_level", 128'(level), 128'(0));
        check("t6_data",  out_data, 128'(0));
        check("t6_last",  128'(out_last), 128'(0));
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 0);
            if (out_valid) seen = 1'b1;
        end
        check("t6_no_stale_rows", 128'(seen), 128'(0));
        tick(1'b1, 7);
        tick(1'b0, 0);
        tick(1'b0, 0);
        tick(1'b0, 0);
        check("t6_resume_valid", 128'(out_valid), 128'(1));
        check("t6_resume_data",  out_data, row_word(7));
        check("t6_resume_last",  128'(out_last), 128'(0));

        // N=1 variant: one-cycle latency, direct path
        out_ready1 = 1'b0;
        in_valid1  = 1'b1;
        col_input1 = 8'h5C;
        check("n1_valid_before", 128'(out_valid1), 128'(0));
        tick(1'b0, 0);
        in_valid1  = 1'b0;
        col_input1 = 8'h00;
        check("n1_valid", 128'(out_valid1), 128'(1));
        check("n1_data",  128'(out_data1), 128'(8'h5C));
        check("n1_last",  128'(out_last1), 128'(0));
        check("n1_level", 128'(level1), 128'(1));
        in_valid1  = 1'b1;
        col_input1 = 8'h3E;
        tick(1'b0, 0);
        in_valid1  = 1'b0;
        col_input1 = 8'h00;
        check("n1_level2", 128'(level1), 128'(2));
        check("n1_head_hold", 128'(out_data1), 128'(8'h5C));
        out_ready1 = 1'b1;
        tick(1'b0, 0);
        check("n1_second_data", 128'(out_data1), 128'(8'h3E));
        check("n1_second_last", 128'(out_last1), 128'(1));
        tick(1'b0, 0);
        check("n1_empty_level", 128'(level1), 128'(0));
        check("n1_empty_data",  128'(out_data1), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
